mux_scanner: RTL and testbench

- Parametrised, registered N:1 multiplexer. Successor to the combinational 4:1 multiplexer.
- Adds configurable data width and channel count.
- Adds an auto-scan mode that steps through the channels with a programmable dwell time.
- Adds a hold/freeze control, valid/wrap status outputs and one-cycle registered latency.
- Sits between multi-channel data sources and a single shared consumer, for example a display or serial output stage.

---
 rtl/mux_scanner_if.sv | 27 ++
 rtl/mux_scanner.sv | 113 +++++++++++
 tb/tb_mux_scanner.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scanner_if.sv
// Channel data, select/control and registered status bundle for mux_scanner.
interface mux_scanner_if #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] X;
    logic [SEL_W-1:0]          C;
    logic                      MODE;
    logic                      HOLD;
    logic [WIDTH-1:0]          Y;
    logic [SEL_W-1:0]          CH;
    logic                      VALID;
    logic                      WRAP;

    // Source/consumer side: drives data and controls, observes the selected output.
    modport master (
        output X, C, MODE, HOLD,
        input  Y, CH, VALID, WRAP
    );

    // Multiplexer side.
    modport slave (
        input  X, C, MODE, HOLD,
        output Y, CH, VALID, WRAP
    );
endinterface

// File: rtl/mux_scanner.sv
// Registered N:1 multiplexer with manual select, auto-scan with programmable
// dwell, hold/freeze and valid/wrap status. All outputs come straight from flops.
module mux_scanner #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned DWELL    = 4
) (
    input logic         clk,
    input logic         resetn,
    mux_scanner_if.slave bus
);
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CHAN_LIM = (SEL_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [SEL_W-1:0] scan_ch;

    function automatic logic in_range(input logic [SEL_W-1:0] s);
        return ({1'b0, s} < CHAN_LIM);
    endfunction

    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] x,
                                              input logic [SEL_W-1:0] s);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (s == SEL_W'(k)) r = x[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    // Next-state and next-output decode; HOLD leaves everything but WRAP untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        scan_ch = ch_q;
        if (!bus.HOLD) begin
            case (state_q)
                StIdle: begin
                    state_d = bus.MODE ? StScan : StManual;
                end
                default: begin
                    if (!bus.MODE) begin
                        state_d = StManual;
                        cnt_d   = '0;
                        ch_d    = bus.C;
                        valid_d = in_range(bus.C);
                        y_d     = in_range(bus.C) ? pick(bus.X, bus.C) : '0;
                    end else begin
                        state_d = StScan;
                        // Not yet scanning a valid channel (fresh from MANUAL or IDLE):
                        // load the start channel with cnt=0 so it gets a full dwell.
                        if (state_q != StScan || !valid_q) begin
                            scan_ch = in_range(ch_q) ? ch_q : '0;
                            cnt_d   = '0;
                        end else if (cnt_q == LAST_CNT) begin
                            cnt_d = '0;
                            if (ch_q == LAST_CH) begin
                                scan_ch = '0;
                                wrap_d  = 1'b1;
                            end else begin
                                scan_ch = ch_q + SEL_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        ch_d    = scan_ch;
                        y_d     = pick(bus.X, scan_ch);
                        valid_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.Y     = y_q;
    assign bus.CH    = ch_q;
    assign bus.VALID = valid_q;
    assign bus.WRAP  = wrap_q;
endmodule

// File: tb/tb_mux_scanner.sv
// Bench for mux_scanner: table-driven manual sweep, directed multi-cycle sequences,
// and randomized traffic against a behavioural model on a 4-channel instance,
// plus directed checks on a 3-channel and a wide DWELL=1 instance.
module tb_mux_scanner;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mux_scanner_if #(.WIDTH(1), .CHANNELS(4), .SEL_W(2)) ifa ();
    mux_scanner_if #(.WIDTH(1), .CHANNELS(3), .SEL_W(2)) ifb ();
    mux_scanner_if #(.WIDTH(8), .CHANNELS(5), .SEL_W(3)) ifc ();

    mux_scanner #(.WIDTH(1), .CHANNELS(4), .SEL_W(2), .DWELL(4)) dut_a (
        .clk(clk), .resetn(resetn), .bus(ifa)
    );
    mux_scanner #(.WIDTH(1), .CHANNELS(3), .SEL_W(2), .DWELL(4)) dut_b (
        .clk(clk), .resetn(resetn), .bus(ifb)
    );
    mux_scanner #(.WIDTH(8), .CHANNELS(5), .SEL_W(3), .DWELL(1)) dut_c (
        .clk(clk), .resetn(resetn), .bus(ifc)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] x;
        logic [1:0] c;
        logic       exp_y;
    } vec_t;
    vec_t tbl[64];

    // Behavioural model of the 4-channel, DWELL=4 instance.
    bit   m_idle, m_scanning;
    int   m_ch, m_el;
    logic m_y, m_valid, m_wrap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_a(input logic rn, input logic [3:0] x, input logic [1:0] c,
                           input logic mode, input logic hold);
        if (!rn) begin
            m_idle = 1; m_scanning = 0; m_ch = 0; m_el = 0;
            m_y = 0; m_valid = 0; m_wrap = 0;
        end else if (hold) begin
            m_wrap = 0;
        end else if (m_idle) begin
            m_idle = 0;
        end else if (!mode) begin
            m_scanning = 0;
            m_ch = int'(c);
            m_valid = (m_ch < 4);
            m_y = m_valid ? x[m_ch] : 1'b0;
            m_wrap = 0;
        end else begin
            if (!m_scanning) begin
                m_scanning = 1;
                if (m_ch >= 4) m_ch = 0;
                m_el = 1;
                m_wrap = 0;
            end else if (m_el == 4) begin
                m_el = 1;
                m_wrap = (m_ch == 3);
                m_ch = (m_ch + 1) % 4;
            end else begin
                m_el++;
                m_wrap = 0;
            end
            m_y = x[m_ch];
            m_valid = 1;
        end
    endtask

    // One clock of the 4-channel instance, compared against the model.
    task automatic step_a(input logic rn, input logic [3:0] x, input logic [1:0] c,
                          input logic mode, input logic hold);
        @(negedge clk);
        resetn = rn; ifa.X = x; ifa.C = c; ifa.MODE = mode; ifa.HOLD = hold;
        @(posedge clk);
        model_a(rn, x, c, mode, hold);
        #1;
        check("model_y", ifa.Y, m_y);
        check("model_ch", ifa.CH, m_ch);
        check("model_valid", ifa.VALID, m_valid);
        check("model_wrap", ifa.WRAP, m_wrap);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] xv;
        logic       mode_r;
        resetn = 1'b0;
        ifa.X = '0; ifa.C = '0; ifa.MODE = 1'b0; ifa.HOLD = 1'b0;
        ifb.X = '0; ifb.C = '0; ifb.MODE = 1'b0; ifb.HOLD = 1'b0;
        ifc.X = '0; ifc.C = '0; ifc.MODE = 1'b0; ifc.HOLD = 1'b0;

        for (int i = 0; i < 64; i++) begin
            xv = 4'(i / 4);
            tbl[i].x = xv;
            tbl[i].c = 2'(i % 4);
            tbl[i].exp_y = xv[i % 4];
        end

        // Reset and the single IDLE cycle.
        step_a(0, 4'hf, 2'd1, 0, 0);
        step_a(0, 4'hf, 2'd1, 0, 0);
        check("reset_y", ifa.Y, 0);
        check("reset_ch", ifa.CH, 0);
        check("reset_valid", ifa.VALID, 0);
        check("reset_wrap", ifa.WRAP, 0);
        step_a(1, 4'hf, 2'd1, 0, 0);
        check("idle_valid", ifa.VALID, 0);
        check("idle_y", ifa.Y, 0);

        // Manual sweep: Y == X[C] one cycle after each change.
        for (int i = 0; i < 64; i++) begin
            step_a(1, tbl[i].x, tbl[i].c, 0, 0);
            check("sweep_y", ifa.Y, tbl[i].exp_y);
            check("sweep_ch", ifa.CH, tbl[i].c);
            check("sweep_valid", ifa.VALID, 1);
        end

        // Scan timing from reset, X=1010.
        xv = 4'b1010;
        step_a(0, xv, 0, 1, 0);
        step_a(1, xv, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            step_a(1, xv, 0, 1, 0);
            check("scan_ch", ifa.CH, (i / 4) % 4);
            check("scan_y", ifa.Y, xv[(i / 4) % 4]);
            check("scan_wrap", ifa.WRAP, (i == 16));
        end

        // Hold at CH=2, cnt=1.
        step_a(0, xv, 0, 1, 0);
        step_a(1, xv, 0, 1, 0);
        for (int i = 0; i < 10; i++) step_a(1, xv, 0, 1, 0);
        check("prehold_ch", ifa.CH, 2);
        for (int i = 0; i < 5; i++) begin
            step_a(1, 4'(~i), 2'(i), 1'(i), 1);
            check("hold_ch", ifa.CH, 2);
            check("hold_y", ifa.Y, 0);
            check("hold_valid", ifa.VALID, 1);
            check("hold_wrap", ifa.WRAP, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step_a(1, xv, 0, 1, 0);
            check("release_ch", ifa.CH, (i < 2) ? 2 : 3);
        end

        // Reset mid-scan at CH=3.
        step_a(0, xv, 0, 1, 0);
        check("midrst_ch", ifa.CH, 0);
        check("midrst_valid", ifa.VALID, 0);
        check("midrst_wrap", ifa.WRAP, 0);
        check("midrst_y", ifa.Y, 0);
        step_a(1, xv, 0, 1, 0);
        check("midrst_idle_valid", ifa.VALID, 0);
        for (int i = 0; i < 5; i++) begin
            step_a(1, xv, 0, 1, 0);
            check("rescan_ch", ifa.CH, (i < 4) ? 0 : 1);
            check("rescan_valid", ifa.VALID, 1);
        end

        // Randomized traffic against the model.
        mode_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mode_r = ~mode_r;
            step_a(($urandom_range(0, 59) != 0), 4'($urandom), 2'($urandom), mode_r,
                   ($urandom_range(0, 7) == 0));
        end

        // 3-channel instance: out-of-range select, then scan entry from it.
        @(negedge clk);
        resetn = 1'b0; ifb.X = 6'b111111; ifb.C = 2'd3; ifb.MODE = 1'b0;
        tick();
        @(negedge clk) resetn = 1'b1;
        tick();
        tick();
        check("oor_y", ifb.Y, 0);
        check("oor_valid", ifb.VALID, 0);
        check("oor_ch", ifb.CH, 3);
        @(negedge clk) ifb.C = 2'd2;
        tick();
        check("inr_y", ifb.Y, 1);
        check("inr_valid", ifb.VALID, 1);
        check("inr_ch", ifb.CH, 2);
        @(negedge clk) ifb.C = 2'd3;
        tick();
        @(negedge clk) ifb.MODE = 1'b1;
        tick();
        check("oor_scan_ch", ifb.CH, 0);
        check("oor_scan_valid", ifb.VALID, 1);

        // Wide, DWELL=1 instance.
        @(negedge clk);
        resetn = 1'b0;
        ifc.X = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        ifc.MODE = 1'b1;
        tick();
        @(negedge clk) resetn = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            check("wide_y", ifc.Y, 8'h10 + 8'(i % 5));
            check("wide_ch", ifc.CH, i % 5);
            check("wide_wrap", ifc.WRAP, (i % 5 == 0) && (i > 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
